// File: rtl/if_id_skid_buffer.sv
// ---------------------------------------------------------------------------
// if_id_skid_buffer
//
// Registered boundary between the IF stage and the combinational ID
// datapath. Holds up to two fetched instructions: a main slot that drives
// ID directly and a skid slot that catches the one instruction IF may
// already have issued when ID stalls. Because of the skid slot, ready_IF
// can be a pure flop decode. IF never has to see stall_ID in the same
// cycle, and a stall never drops an instruction.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   INST_IF, PC_IF,
//   PC_plus_4_IF         fetched instruction and its PCs
//   valid_IF / ready_IF  IF handshake (push = valid_IF & ready_IF)
//   stall_ID             ID cannot consume the main slot this cycle
//   flush                drop every held and incoming instruction
//   *_IF_ID_o            main-slot contents (NOP bubble when empty)
//   valid_IF_ID_o        main slot holds a real instruction
//   occupancy            number of held entries, 0..2
// ---------------------------------------------------------------------------
module if_id_skid_buffer #(
  parameter int unsigned INST_WIDTH      = 32,
  parameter int unsigned INST_ADDR_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h0000_0013)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INST_WIDTH-1:0]      INST_IF,
  input  logic [INST_ADDR_WIDTH-1:0] PC_IF,
  input  logic [INST_ADDR_WIDTH-1:0] PC_plus_4_IF,
  input  logic                       valid_IF,
  output logic                       ready_IF,
  input  logic                       stall_ID,
  input  logic                       flush,
  output logic [INST_WIDTH-1:0]      INST_IF_ID_o,
  output logic [INST_ADDR_WIDTH-1:0] PC_IF_ID_o,
  output logic [INST_ADDR_WIDTH-1:0] PC_plus_4_IF_ID_o,
  output logic                       valid_IF_ID_o,
  output logic [1:0]                 occupancy
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e r_state, w_state_d;

  // Main slot (what ID sees).
  logic [INST_WIDTH-1:0]      r_main_inst, w_main_inst_d;
  logic [INST_ADDR_WIDTH-1:0] r_main_pc, w_main_pc_d;
  logic [INST_ADDR_WIDTH-1:0] r_main_pc4, w_main_pc4_d;

  // Skid slot; only meaningful in StTwo, where it is the younger entry.
  logic [INST_WIDTH-1:0]      r_skid_inst, w_skid_inst_d;
  logic [INST_ADDR_WIDTH-1:0] r_skid_pc, w_skid_pc_d;
  logic [INST_ADDR_WIDTH-1:0] r_skid_pc4, w_skid_pc4_d;

  logic w_push;
  logic w_pop;

  // All outputs are flops or decodes of the state flop.
  assign ready_IF          = (r_state != StTwo);
  assign valid_IF_ID_o     = (r_state != StEmpty);
  assign occupancy         = r_state;
  assign INST_IF_ID_o      = r_main_inst;
  assign PC_IF_ID_o        = r_main_pc;
  assign PC_plus_4_IF_ID_o = r_main_pc4;

  assign w_push = valid_IF & ready_IF;
  assign w_pop  = valid_IF_ID_o & ~stall_ID;

  always_comb begin
    w_state_d     = r_state;
    w_main_inst_d = r_main_inst;
    w_main_pc_d   = r_main_pc;
    w_main_pc4_d  = r_main_pc4;
    w_skid_inst_d = r_skid_inst;
    w_skid_pc_d   = r_skid_pc;
    w_skid_pc4_d  = r_skid_pc4;

    if (flush) begin
      // Flush beats everything: held entries, the incoming push and any stall.
      w_state_d     = StEmpty;
      w_main_inst_d = NOP_INST;
      w_main_pc_d   = '0;
      w_main_pc4_d  = '0;
      w_skid_inst_d = NOP_INST;
      w_skid_pc_d   = '0;
      w_skid_pc4_d  = '0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          // A stall with nothing in the main slot has no effect.
          if (w_push) begin
            w_state_d     = StOne;
            w_main_inst_d = INST_IF;
            w_main_pc_d   = PC_IF;
            w_main_pc4_d  = PC_plus_4_IF;
          end
        end

        StOne: begin
          if (w_push && w_pop) begin
            w_main_inst_d = INST_IF;
            w_main_pc_d   = PC_IF;
            w_main_pc4_d  = PC_plus_4_IF;
          end else if (w_push) begin
            // ID is stalled: park the new instruction behind the main slot.
            w_state_d     = StTwo;
            w_skid_inst_d = INST_IF;
            w_skid_pc_d   = PC_IF;
            w_skid_pc4_d  = PC_plus_4_IF;
          end else if (w_pop) begin
            w_state_d     = StEmpty;
            w_main_inst_d = NOP_INST;
            w_main_pc_d   = '0;
            w_main_pc4_d  = '0;
          end
        end

        StTwo: begin
          // ready_IF is low here, so only a pop can move the state.
          if (w_pop) begin
            w_state_d     = StOne;
            w_main_inst_d = r_skid_inst;
            w_main_pc_d   = r_skid_pc;
            w_main_pc4_d  = r_skid_pc4;
            w_skid_inst_d = NOP_INST;
            w_skid_pc_d   = '0;
            w_skid_pc4_d  = '0;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean bubble.
          w_state_d     = StEmpty;
          w_main_inst_d = NOP_INST;
          w_main_pc_d   = '0;
          w_main_pc4_d  = '0;
          w_skid_inst_d = NOP_INST;
          w_skid_pc_d   = '0;
          w_skid_pc4_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StEmpty;
      r_main_inst <= NOP_INST;
      r_main_pc   <= '0;
      r_main_pc4  <= '0;
      r_skid_inst <= NOP_INST;
      r_skid_pc   <= '0;
      r_skid_pc4  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_main_inst <= w_main_inst_d;
      r_main_pc   <= w_main_pc_d;
      r_main_pc4  <= w_main_pc4_d;
      r_skid_inst <= w_skid_inst_d;
      r_skid_pc   <= w_skid_pc_d;
      r_skid_pc4  <= w_skid_pc4_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_id_skid_buffer
//
// Directed scenarios followed by randomized traffic. Expected outputs come
// from a FIFO model: a queue of at most two entries, the head drives ID.
// ---------------------------------------------------------------------------
module tb_if_id_skid_buffer;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_if;
  logic [31:0] pc_if;
  logic [31:0] pc4_if;
  logic        valid_if;
  logic        ready_if;
  logic        stall_id;
  logic        flush;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        valid_o;
  logic [1:0]  occ_o;

  if_id_skid_buffer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .INST_IF          (inst_if),
    .PC_IF            (pc_if),
    .PC_plus_4_IF     (pc4_if),
    .valid_IF         (valid_if),
    .ready_IF         (ready_if),
    .stall_ID         (stall_id),
    .flush            (flush),
    .INST_IF_ID_o     (inst_o),
    .PC_IF_ID_o       (pc_o),
    .PC_plus_4_IF_ID_o(pc4_o),
    .valid_IF_ID_o    (valid_o),
    .occupancy        (occ_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  ent_t model_q[$];

  int unsigned n_vec;
  int unsigned n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model's view of the buffer.
  task automatic check_all(input string tag);
    int unsigned sz;
    sz = model_q.size();
    if (sz > 0) begin
      check_eq({tag, " inst"}, inst_o, model_q[0].inst);
      check_eq({tag, " pc"}, pc_o, model_q[0].pc);
      check_eq({tag, " pc4"}, pc4_o, model_q[0].pc4);
    end else begin
      check_eq({tag, " inst"}, inst_o, Nop);
      check_eq({tag, " pc"}, pc_o, 32'h0);
      check_eq({tag, " pc4"}, pc4_o, 32'h0);
    end
    check_eq({tag, " valid"}, {31'b0, valid_o}, {31'b0, (sz != 0)});
    check_eq({tag, " occ"}, {30'b0, occ_o}, sz);
    check_eq({tag, " ready"}, {31'b0, ready_if}, {31'b0, (sz < 2)});
  endtask

  // One clock: drive at negedge, update the model at posedge, check at the
  // following negedge.
  task automatic cycle(input logic v, input logic st, input logic fl,
                       input logic [31:0] inst, input logic [31:0] pc,
                       input string tag);
    logic m_push;
    logic m_pop;
    ent_t e;
    valid_if = v;
    stall_id = st;
    flush    = fl;
    inst_if  = inst;
    pc_if    = pc;
    pc4_if   = pc + 32'd4;
    m_push   = v && (model_q.size() < 2);
    m_pop    = (model_q.size() > 0) && !st;
    e.inst   = inst;
    e.pc     = pc;
    e.pc4    = pc + 32'd4;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(e);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, tag);
  endtask

  initial begin
    logic        hold;
    logic        rv;
    logic        rst;
    logic        rfl;
    logic [31:0] rinst;
    logic [31:0] rpc;

    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    valid_if = 1'b0;
    stall_id = 1'b0;
    flush    = 1'b0;
    inst_if  = '0;
    pc_if    = '0;
    pc4_if   = '0;

    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post-reset");

    // Streaming: one-cycle latency, occupancy stays 1.
    cycle(1'b1, 1'b0, 1'b0, 32'hA000_0001, 32'h0, "stream0");
    check_eq("stream0 pc", pc_o, 32'h0);
    check_eq("stream0 pc4", pc4_o, 32'h4);
    cycle(1'b1, 1'b0, 1'b0, 32'hA000_0002, 32'h4, "stream1");
    check_eq("stream1 pc", pc_o, 32'h4);
    check_eq("stream1 pc4", pc4_o, 32'h8);
    cycle(1'b1, 1'b0, 1'b0, 32'hA000_0003, 32'h8, "stream2");
    check_eq("stream2 pc", pc_o, 32'h8);
    check_eq("stream2 pc4", pc4_o, 32'hC);
    check_eq("stream2 occ", {30'b0, occ_o}, 32'd1);
    idle("stream drain");

    // Stall fill: second push lands in the skid slot.
    cycle(1'b1, 1'b0, 1'b0, 32'hB000_0010, 32'h10, "fill0");
    cycle(1'b1, 1'b1, 1'b0, 32'hB000_0014, 32'h14, "fill1");
    check_eq("fill occ", {30'b0, occ_o}, 32'd2);
    check_eq("fill ready", {31'b0, ready_if}, 32'd0);
    check_eq("fill pc", pc_o, 32'h10);
    idle("fill release");
    check_eq("release pc", pc_o, 32'h14);
    check_eq("release ready", {31'b0, ready_if}, 32'd1);
    idle("fill drain");

    // Flush with a full buffer and a concurrent push.
    cycle(1'b1, 1'b0, 1'b0, 32'hC000_0020, 32'h20, "flfill0");
    cycle(1'b1, 1'b1, 1'b0, 32'hC000_0024, 32'h24, "flfill1");
    check_eq("flfill occ", {30'b0, occ_o}, 32'd2);
    cycle(1'b1, 1'b1, 1'b1, 32'hC000_0028, 32'h28, "flush");
    check_eq("flush valid", {31'b0, valid_o}, 32'd0);
    check_eq("flush inst", inst_o, Nop);
    check_eq("flush occ", {30'b0, occ_o}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'hC000_0100, 32'h100, "post-flush");
    check_eq("post-flush pc", pc_o, 32'h100);
    check_eq("post-flush occ", {30'b0, occ_o}, 32'd1);
    idle("post-flush drain");

    // Drain to empty, then a stall with nothing held.
    cycle(1'b1, 1'b0, 1'b0, 32'hD000_0030, 32'h30, "drain0");
    idle("drain1");
    check_eq("drain inst", inst_o, Nop);
    check_eq("drain valid", {31'b0, valid_o}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "empty stall");
    check_eq("empty stall occ", {30'b0, occ_o}, 32'd0);

    // Asynchronous reset while full.
    cycle(1'b1, 1'b0, 1'b0, 32'hE000_0040, 32'h40, "rfill0");
    cycle(1'b1, 1'b1, 1'b0, 32'hE000_0044, 32'h44, "rfill1");
    valid_if = 1'b0;
    stall_id = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    check_all("async reset");
    check_eq("async reset inst", inst_o, Nop);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("reset release");

    // Random traffic; IF keeps an unaccepted instruction stable.
    hold  = 1'b0;
    rinst = '0;
    rpc   = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        rv    = ($urandom_range(0, 99) < 70);
        rinst = $urandom;
        rpc   = $urandom & 32'hFFFF_FFFC;
      end else begin
        rv = 1'b1;
      end
      rst  = ($urandom_range(0, 2) == 0);
      rfl  = ($urandom_range(0, 15) == 0);
      hold = rv && (model_q.size() >= 2) && !rfl;
      cycle(rv, rst, rfl, rinst, rpc, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
- Registered boundary between the IF stage and the combinational ID datapath; replaces a plain IF/ID flop.
- Two-entry buffer: a main output slot plus one skid slot. IF can issue with a registered ready, and hazard stalls from ID never drop a fetched instruction.
- Supports synchronous flush on taken branch/jump. When the main slot is empty or flushed, ID sees a NOP bubble.

Parameters:
- INST_WIDTH, 32, instruction width.
- INST_ADDR_WIDTH, 32, PC width.
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- INST_IF  input  INST_WIDTH  fetched instruction.
- PC_IF  input  INST_ADDR_WIDTH  PC of fetched instruction.
- PC_plus_4_IF  input  INST_ADDR_WIDTH  PC+4 of fetched instruction.
- valid_IF  input  1  IF presents an instruction this cycle.
- ready_IF  output  1  buffer accepts IF data this cycle; registered (function of state only).
- stall_ID  input  1  ID/hazard unit cannot consume the main slot this cycle.
- flush  input  1  discard all buffered and incoming instructions.
- INST_IF_ID_o  output  INST_WIDTH  main-slot instruction to ID.
- PC_IF_ID_o  output  INST_ADDR_WIDTH  main-slot PC.
- PC_plus_4_IF_ID_o  output  INST_ADDR_WIDTH  main-slot PC+4.
- valid_IF_ID_o  output  1  main slot holds a real instruction.
- occupancy  output  2  number of held entries, 0..2.

Behaviour:
- Reset (async, rst_n=0): state EMPTY; INST_IF_ID_o=NOP_INST; PC_IF_ID_o=0; PC_plus_4_IF_ID_o=0; valid_IF_ID_o=0; skid slot cleared; occupancy=0; ready_IF=1. Deassertion is taken on the next clk edge, with no glitch on outputs.
- Events:
  - push = valid_IF & ready_IF.
  - pop = valid_IF_ID_o & ~stall_ID.
- ready_IF = 1 in EMPTY and ONE, 0 in TWO.
- Latency: an instruction pushed in cycle N appears on the *_IF_ID_o outputs in cycle N+1 if the main slot is free or being popped. Otherwise it enters the skid slot.
- State machine (occupancy = 0/1/2):
  - EMPTY: push -> ONE, main <= IF data, valid=1. No push -> stay; outputs remain NOP, valid=0.
  - ONE, push & pop -> ONE: main <= IF data.
  - ONE, push & ~pop -> TWO: skid <= IF data; main unchanged.
  - ONE, ~push & pop -> EMPTY: main <= NOP_INST, PCs <= 0, valid <= 0.
  - ONE, ~push & ~pop -> hold.
  - TWO: no push is possible. pop -> ONE: main <= skid. ~pop -> hold.
- Ordering: strictly FIFO; the skid entry is always older than any later push.
- Flush has highest priority:
  - Next state is EMPTY and the main slot is set to the reset bubble values.
  - Skid is discarded.
  - Any push in the same cycle is discarded; ready_IF reads 1 the following cycle.
  - stall_ID is ignored during flush.
- A stall while the main slot is empty has no effect; valid stays 0.
- No combinational path from any input to any output; every output is a flop or decoded from flops.
- A push when ready_IF=0 cannot occur; the bench asserts valid_IF is never dropped silently, i.e. IF holds its data until ready_IF is high.

Test Plan:
- Reset mid-stream: TWO state, drop rst_n asynchronously -> outputs immediately NOP_INST=0x00000013, PC=0, valid=0, occupancy=0, ready_IF=1.
- Streaming: push PC 0x0,0x4,0x8 on consecutive cycles, stall_ID=0 -> PC_IF_ID_o shows 0x0,0x4,0x8 one cycle later each; PC_plus_4 shows 0x4,0x8,0xC; occupancy stays 1.
- Stall fill: push PC 0x10 (ONE), then stall_ID=1 with push 0x14 -> occupancy=2, ready_IF=0, output holds 0x10. Release stall -> 0x10 consumed, output 0x14 next cycle, ready_IF=1.
- Flush with full buffer: occupancy=2 (0x20 main, 0x24 skid), flush=1 with valid_IF=1 PC 0x28 -> next cycle valid=0, INST=0x00000013, occupancy=0. Next push 0x100 appears alone.
- Drain to empty: occupancy=1 holding 0x30, no push, pop -> output returns to NOP, valid=0, occupancy=0. Subsequent stall_ID=1 keeps state EMPTY.
